// File: rtl/counter_pkg.sv
// Shared types, default sizing and the modular step function for the 4-bit counter datapath.
package counter_pkg;

  localparam int unsigned CNT_WIDTH = 4;
  localparam int unsigned CNT_MOD   = 16;

  typedef logic [CNT_WIDTH-1:0] count_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // One modular step; operands are widened so any WIDTH up to 8 fits.
  function automatic logic [7:0] next_count(input logic [7:0] count,
                                            input logic up_dn,
                                            input int unsigned mod);
    int unsigned c;
    c = 32'(count);
    if (up_dn) c = (c == mod - 32'd1) ? 32'd0 : c + 32'd1;
    else       c = (c == 32'd0) ? mod - 32'd1 : c - 32'd1;
    return 8'(c);
  endfunction

endpackage

// File: rtl/dff_ms_asyn_rstn.sv
// Master-slave D flip-flop from a clk-low master latch and a clk-high slave stage,
// both cleared asynchronously by reset_n to RST_VAL.
module dff_ms_asyn_rstn #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic m;

  always_latch begin
    if (!reset_n)  m <= RST_VAL;
    else if (!clk) m <= d;
  end

  // The slave is only open while the master is closed, so it behaves as a rising-edge capture of m.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= RST_VAL;
    else          q <= m;
  end

endmodule

// File: rtl/counter_4bit_ms.sv
// Up/down modulus counter with load, terminal count and wrap pulse, stored in master-slave flops.
// Optional build macro COUNTER_SATURATE_EN: saturate at the ends instead of wrapping.
module counter_4bit_ms
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = CNT_WIDTH,
  parameter int unsigned MOD       = CNT_MOD,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_W    = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] RST_BITS = WIDTH'(RESET_VAL);

  dir_e             dir;
  logic             load_ok;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] count_d;
  logic             wrap_d;

  assign dir      = dir_e'(up_dn);
  assign tc       = (dir == DIR_UP) ? (count == MAX_V) : (count == '0);
  assign load_ok  = ({1'b0, load_val} < MOD_W);
  assign step_val = WIDTH'(next_count(8'(count), up_dn, MOD));

  always_comb begin
    count_d = count;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_ok ? load_val : MAX_V;
    end else if (en) begin
`ifdef COUNTER_SATURATE_EN
      count_d = tc ? count : step_val;
`else
      count_d = step_val;
      wrap_d  = tc;
`endif
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_ms_asyn_rstn #(
      .RST_VAL(RST_BITS[i])
    ) u_ff (
      .clk    (clk),
      .reset_n(reset_n),
      .d      (count_d[i]),
      .q      (count[i])
    );
  end

  dff_ms_asyn_rstn #(
    .RST_VAL(1'b0)
  ) u_wrap_ff (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (wrap_d),
    .q      (wrap)
  );

endmodule
